// File: rtl/ir_packer.sv
// tiny8 instruction-word packer: packs field sets into 8-bit words, buffers them in a
// small FIFO and streams them to instruction memory at consecutive addresses.
module ir_packer #(
    parameter int                 DEPTH     = 4,
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_opcode,
    input  logic [1:0]        in_rs,
    input  logic [1:0]        in_rd,
    input  logic [1:0]        in_delta2,
    input  logic [3:0]        in_imm4,
    input  logic              in_imm,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_resp,
    output logic              busy,
    output logic [15:0]       words_written
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic [ADDR_W-1:0] addr, addr_nxt, mem_addr_nxt;
    logic [7:0]        mem_wdata_nxt;
    logic              mem_write_nxt;
    logic [15:0]       ww_nxt;

    function automatic logic [7:0] pack_word(input logic [1:0] op, input logic [1:0] rs,
                                             input logic [1:0] rd, input logic [1:0] d2,
                                             input logic [3:0] imm4, input logic imm);
        return {op, rs, imm ? imm4 : {rd, d2}};
    endfunction

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (count != '0) || (state == WRITE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An address load in IDLE takes priority over starting a queued write.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!load_addr && (count != '0)) state_nxt = WRITE;
            WRITE:   if (mem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_write_nxt = mem_write;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        addr_nxt      = addr;
        ww_nxt        = words_written;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (load_addr) begin
                    addr_nxt = addr_in;
                end else if (count != '0) begin
                    mem_write_nxt = 1'b1;
                    mem_addr_nxt  = addr;
                    mem_wdata_nxt = fifo_mem[rd_ptr];
                end
            end
            WRITE: begin
                if (mem_resp) begin
                    mem_write_nxt = 1'b0;
                    pop           = 1'b1;
                    addr_nxt      = addr + ADDR_W'(1);
                    ww_nxt        = words_written + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_write     <= 1'b0;
            mem_addr      <= BASE_ADDR;
            mem_wdata     <= 8'h00;
            addr          <= BASE_ADDR;
            words_written <= 16'd0;
        end else begin
            mem_write     <= mem_write_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_wdata     <= mem_wdata_nxt;
            addr          <= addr_nxt;
            words_written <= ww_nxt;
        end
    end

    // The head stays in the FIFO until the write is acknowledged, so it counts toward occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= pack_word(in_opcode, in_rs, in_rd, in_delta2, in_imm4, in_imm);
    end

endmodule

// File: tb/tb_ir_packer.sv
// Bench for ir_packer: transaction-level model of the FIFO, address counter and memory bus,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ir_packer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, in_imm, load_addr;
    logic [1:0]        in_opcode, in_rs, in_rd, in_delta2;
    logic [3:0]        in_imm4;
    logic [ADDR_W-1:0] addr_in, mem_addr;
    logic              mem_write, mem_resp, busy;
    logic [7:0]        mem_wdata;
    logic [15:0]       words_written;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: queued words (head is the one being written), write-in-flight flag,
    // next write address, last bus contents, acknowledged count.
    logic [7:0]        mq[$];
    bit                m_inflight;
    logic [ADDR_W-1:0] m_addr, m_baddr;
    logic [7:0]        m_bdata;
    logic [15:0]       m_ww;
    bit                en = 1'b0;

    always #5 clk = ~clk;

    ir_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(8'h00)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rd(in_rd), .in_delta2(in_delta2),
        .in_imm4(in_imm4), .in_imm(in_imm), .load_addr(load_addr), .addr_in(addr_in),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .busy(busy), .words_written(words_written)
    );

    function automatic logic [7:0] pack(input int op, input int rs, input int rd, input int d2,
                                        input int imm4, input bit imm);
        return 8'(op * 64 + rs * 16 + (imm ? imm4 : rd * 4 + d2));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; the model takes the inputs that were applied before the edge.
    task automatic cycle();
        bit                r    = rst;
        bit                ld   = load_addr;
        bit                resp = mem_resp;
        bit                do_push = in_valid && (mq.size() < DEPTH);
        logic [ADDR_W-1:0] ai   = addr_in;
        logic [7:0]        w    = pack(int'(in_opcode), int'(in_rs), int'(in_rd),
                                       int'(in_delta2), int'(in_imm4), in_imm);
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_inflight = 1'b0;
            m_addr     = 8'h00;
            m_baddr    = 8'h00;
            m_bdata    = 8'h00;
            m_ww       = 16'd0;
            en         = 1'b1;
        end else begin
            if (!m_inflight) begin
                if (ld) m_addr = ai;
                else if (mq.size() > 0) begin
                    m_inflight = 1'b1;
                    m_baddr    = m_addr;
                    m_bdata    = mq[0];
                end
            end else if (resp) begin
                m_inflight = 1'b0;
                void'(mq.pop_front());
                m_addr = m_addr + 8'd1;
                m_ww   = m_ww + 16'd1;
            end
            if (do_push) mq.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("mem_write", 32'(mem_write), 32'(m_inflight));
            chk("mem_addr", 32'(mem_addr), 32'(m_baddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_bdata));
            chk("words_written", 32'(words_written), 32'(m_ww));
            chk("busy", 32'(busy), 32'(mq.size() != 0 || m_inflight));
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        end
    end

    task automatic set_fields(input int op, input int rs, input int rd, input int d2,
                              input int imm4, input bit imm);
        in_opcode = 2'(op);
        in_rs     = 2'(rs);
        in_rd     = 2'(rd);
        in_delta2 = 2'(d2);
        in_imm4   = 4'(imm4);
        in_imm    = imm;
    endtask

    task automatic push_word(input int op, input int rs, input int rd, input int d2,
                             input int imm4, input bit imm);
        bit acc = 1'b0;
        set_fields(op, rs, rd, d2, imm4, imm);
        in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            acc = in_ready;
            cycle();
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_write(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_write) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input bit resp);
        mem_resp = resp;
        for (int k = 0; k < n; k++) cycle();
        mem_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; load_addr = 1'b0; addr_in = '0; mem_resp = 1'b0;
        set_fields(0, 0, 0, 0, 0, 1'b0);
        chk("pack_reg_form", 32'(pack(2, 1, 3, 2, 0, 1'b0)), 32'h9E);
        chk("pack_imm_form", 32'(pack(1, 2, 3, 3, 10, 1'b1)), 32'h6A);
        cycle();
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h00);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h00);
        chk("rst_words", 32'(words_written), 32'd0);

        // Register form and push-to-strobe latency.
        push_word(2, 1, 3, 2, 0, 1'b0);
        chk("s1_mw_after_push", 32'(mem_write), 32'd0);
        cycle();
        chk("s1_mw_latency", 32'(mem_write), 32'd1);
        chk("s1_addr", 32'(mem_addr), 32'h00);
        chk("s1_wdata", 32'(mem_wdata), 32'h9E);
        idle(1, 1'b1);
        chk("s1_words", 32'(words_written), 32'd1);
        idle(2, 1'b0);

        // Immediate form ignores rd/delta2.
        push_word(1, 2, 3, 3, 10, 1'b1);
        wait_write("s2_write_seen");
        chk("s2_wdata", 32'(mem_wdata), 32'h6A);
        chk("s2_addr", 32'(mem_addr), 32'h01);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Stalled memory fills the FIFO; fifth word held off, head stays on the bus.
        push_word(3, 0, 1, 1, 0, 1'b0);
        for (int i = 0; i < 3; i++) push_word(i, i + 1, 2, i, 5, 1'b0);
        chk("s3_full_ready", 32'(in_ready), 32'd0);
        set_fields(1, 1, 1, 1, 7, 1'b1);
        in_valid = 1'b1;
        idle(3, 1'b0);
        chk("s3_held_ready", 32'(in_ready), 32'd0);
        chk("s3_head_wdata", 32'(mem_wdata), 32'hC5);
        chk("s3_head_write", 32'(mem_write), 32'd1);
        mem_resp = 1'b1;
        push_word(1, 1, 1, 1, 7, 1'b1);
        idle(30, 1'b1);

        // Address load and wrap from 8'hFF to 8'h00.
        do_reset();
        load_addr = 1'b1; addr_in = 8'hFF;
        cycle();
        load_addr = 1'b0;
        push_word(0, 1, 2, 3, 0, 1'b0);
        push_word(3, 2, 1, 0, 0, 1'b0);
        wait_write("s4_first_seen");
        chk("s4_addr_ff", 32'(mem_addr), 32'hFF);
        idle(1, 1'b1);
        wait_write("s4_second_seen");
        chk("s4_addr_wrap", 32'(mem_addr), 32'h00);
        idle(1, 1'b1);
        chk("s4_words", 32'(words_written), 32'd2);

        // load_addr during a write is dropped.
        do_reset();
        push_word(2, 2, 2, 2, 0, 1'b0);
        wait_write("s5_first_seen");
        load_addr = 1'b1; addr_in = 8'h40;
        cycle();
        load_addr = 1'b0;
        idle(1, 1'b1);
        push_word(1, 3, 0, 1, 0, 1'b0);
        wait_write("s5_second_seen");
        chk("s5_addr_after_drop", 32'(mem_addr), 32'h01);
        idle(1, 1'b1);

        // Reset in the middle of a write with words queued behind it.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(i, 3 - i, 1, 2, 9, 1'b0);
        wait_write("s6_write_seen");
        do_reset();
        chk("s6_mem_write", 32'(mem_write), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_in_ready", 32'(in_ready), 32'd1);
        chk("s6_mem_addr", 32'(mem_addr), 32'h00);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_opcode = 2'($urandom);
            in_rs     = 2'($urandom);
            in_rd     = 2'($urandom);
            in_delta2 = 2'($urandom);
            in_imm4   = 4'($urandom);
            in_imm    = 1'($urandom);
            load_addr = ($urandom_range(0, 9) == 0);
            addr_in   = 8'($urandom);
            mem_resp  = ($urandom_range(0, 1) == 1);
            cycle();
        end
        rst = 1'b0; in_valid = 1'b0; load_addr = 1'b0; mem_resp = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
